dm_sba_axil_bridge: RTL and testbench

Downstream stage of the debug module's system bus access (SBA) master. It converts the simple single-outstanding req/gnt/r_valid master port into an AXI4-Lite master. It returns read data, write completion and bus error status to the SBA logic, and a watchdog converts a hung bus into an error completion.

---
 rtl/dm_sba_axil_bridge.sv | 231 +++++++++++++++++++++++
 tb/tb_dm_sba_axil_bridge.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_sba_axil_bridge.sv
// SBA master port (req/gnt/r_valid, one outstanding) to AXI4-Lite master bridge.
// A watchdog turns a hung bus into an error completion and then drains the late response.
module dm_sba_axil_bridge #(
    parameter int unsigned BusWidth      = 32,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dmactive_i,
    input  logic                  req_i,
    input  logic [BusWidth-1:0]   add_i,
    input  logic                  we_i,
    input  logic [BusWidth-1:0]   wdata_i,
    input  logic [BusWidth/8-1:0] be_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    output logic [BusWidth-1:0]   r_rdata_o,
    output logic                  r_err_o,
    output logic [BusWidth-1:0]   awaddr_o,
    output logic [2:0]            awprot_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [BusWidth-1:0]   wdata_o,
    output logic [BusWidth/8-1:0] wstrb_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o,
    output logic [BusWidth-1:0]   araddr_o,
    output logic [2:0]            arprot_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [BusWidth-1:0]   rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    output logic [2:0]            state_o
);

    localparam int unsigned BeWidth  = BusWidth / 8;
    localparam int unsigned CntWidth = $clog2(TimeoutCycles);
    // The counter is one increment short of TimeoutCycles-1 here, so the error
    // pulse lands exactly TimeoutCycles cycles after the grant.
    localparam logic [CntWidth-1:0] CntFire = CntWidth'(TimeoutCycles - 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RRESP = 3'd4,
        DRAIN = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [BusWidth-1:0]   addr_q, addr_d;
    logic [BusWidth-1:0]   wdata_q, wdata_d;
    logic [BeWidth-1:0]    be_q, be_d;
    logic                  we_q, we_d;
    logic                  aw_q, aw_d;
    logic                  w_q, w_d;
    logic                  ar_q, ar_d;
    logic                  resp_seen_q, resp_seen_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  r_valid_q, r_valid_d;
    logic                  r_err_q, r_err_d;
    logic [BusWidth-1:0]   r_rdata_q, r_rdata_d;
    logic                  timeout;
    logic                  drain_resp;

    assign timeout = (cnt_q == CntFire);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        we_d        = we_q;
        aw_d        = aw_q;
        w_d         = w_q;
        ar_d        = ar_q;
        resp_seen_d = resp_seen_q;
        cnt_d       = cnt_q;
        r_valid_d   = 1'b0;
        r_err_d     = 1'b0;
        r_rdata_d   = r_rdata_q;
        gnt_o       = 1'b0;
        bready_o    = 1'b0;
        rready_o    = 1'b0;
        drain_resp  = 1'b0;

        if (state_q inside {WADDR, WRESP, RADDR, RRESP}) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                gnt_o = req_i & dmactive_i;
                if (gnt_o) begin
                    addr_d      = add_i;
                    wdata_d     = wdata_i;
                    be_d        = be_i;
                    we_d        = we_i;
                    cnt_d       = '0;
                    resp_seen_d = 1'b0;
                    if (we_i) begin
                        aw_d    = 1'b1;
                        w_d     = 1'b1;
                        state_d = WADDR;
                    end else begin
                        ar_d    = 1'b1;
                        state_d = RADDR;
                    end
                end
            end
            WADDR: begin
                if (awready_i) aw_d = 1'b0;
                if (wready_i)  w_d  = 1'b0;
                if (timeout) begin
                    state_d   = DRAIN;
                    r_valid_d = 1'b1;
                    r_err_d   = 1'b1;
                    r_rdata_d = '0;
                end else if (!aw_d && !w_d) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                bready_o = 1'b1;
                if (bvalid_i) begin
                    state_d   = IDLE;
                    r_valid_d = 1'b1;
                    r_err_d   = (bresp_i != 2'b00);
                    r_rdata_d = '0;
                end else if (timeout) begin
                    state_d   = DRAIN;
                    r_valid_d = 1'b1;
                    r_err_d   = 1'b1;
                    r_rdata_d = '0;
                end
            end
            RADDR: begin
                if (arready_i) ar_d = 1'b0;
                if (timeout) begin
                    state_d   = DRAIN;
                    r_valid_d = 1'b1;
                    r_err_d   = 1'b1;
                    r_rdata_d = '0;
                end else if (arready_i) begin
                    state_d = RRESP;
                end
            end
            RRESP: begin
                rready_o = 1'b1;
                if (rvalid_i) begin
                    state_d   = IDLE;
                    r_valid_d = 1'b1;
                    r_err_d   = (rresp_i != 2'b00);
                    r_rdata_d = rdata_i;
                end else if (timeout) begin
                    state_d   = DRAIN;
                    r_valid_d = 1'b1;
                    r_err_d   = 1'b1;
                    r_rdata_d = '0;
                end
            end
            DRAIN: begin
                // Finish any open address/data handshake, swallow the late response silently.
                if (awready_i) aw_d = 1'b0;
                if (wready_i)  w_d  = 1'b0;
                if (arready_i) ar_d = 1'b0;
                bready_o   = we_q;
                rready_o   = ~we_q;
                drain_resp = we_q ? bvalid_i : rvalid_i;
                if (drain_resp) resp_seen_d = 1'b1;
                if ((resp_seen_q || drain_resp) && !aw_d && !w_d && !ar_d) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            aw_q        <= 1'b0;
            w_q         <= 1'b0;
            ar_q        <= 1'b0;
            resp_seen_q <= 1'b0;
            cnt_q       <= '0;
            r_valid_q   <= 1'b0;
            r_err_q     <= 1'b0;
            r_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            we_q        <= we_d;
            aw_q        <= aw_d;
            w_q         <= w_d;
            ar_q        <= ar_d;
            resp_seen_q <= resp_seen_d;
            cnt_q       <= cnt_d;
            r_valid_q   <= r_valid_d;
            r_err_q     <= r_err_d;
            r_rdata_q   <= r_rdata_d;
        end
    end

    assign r_valid_o = r_valid_q;
    assign r_err_o   = r_err_q;
    assign r_rdata_o = r_rdata_q;
    assign awaddr_o  = addr_q;
    assign araddr_o  = addr_q;
    assign awprot_o  = 3'b000;
    assign arprot_o  = 3'b000;
    assign awvalid_o = aw_q;
    assign wvalid_o  = w_q;
    assign arvalid_o = ar_q;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = be_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_dm_sba_axil_bridge.sv
// Directed bench for dm_sba_axil_bridge: 32-bit instance with an 8-cycle watchdog
// and a 64-bit instance; completions are checked by queue-driven monitors.
module tb_dm_sba_axil_bridge;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        dmactive, req, we, gnt, r_valid, r_err;
    logic [31:0] add, wdata, r_rdata, awaddr, axi_wdata, araddr, rdata;
    logic [3:0]  be, wstrb;
    logic [2:0]  awprot, arprot, state;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    // 64-bit instance
    logic        dmactive_b, req_b, we_b, gnt_b, r_valid_b, r_err_b;
    logic [63:0] add_b, wdata_b, r_rdata_b, awaddr_b, axi_wdata_b, araddr_b, rdata_b;
    logic [7:0]  be_b, wstrb_b;
    logic [2:0]  awprot_b, arprot_b, state_b;
    logic        awvalid_b, awready_b, wvalid_b, wready_b, bvalid_b, bready_b;
    logic        arvalid_b, arready_b, rvalid_b, rready_b;
    logic [1:0]  bresp_b, rresp_b;

    dm_sba_axil_bridge #(.BusWidth(32), .TimeoutCycles(8)) dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .dmactive_i(dmactive), .req_i(req), .add_i(add),
        .we_i(we), .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .r_valid_o(r_valid),
        .r_rdata_o(r_rdata), .r_err_o(r_err), .awaddr_o(awaddr), .awprot_o(awprot),
        .awvalid_o(awvalid), .awready_i(awready), .wdata_o(axi_wdata), .wstrb_o(wstrb),
        .wvalid_o(wvalid), .wready_i(wready), .bresp_i(bresp), .bvalid_i(bvalid),
        .bready_o(bready), .araddr_o(araddr), .arprot_o(arprot), .arvalid_o(arvalid),
        .arready_i(arready), .rdata_i(rdata), .rresp_i(rresp), .rvalid_i(rvalid),
        .rready_o(rready), .state_o(state)
    );

    dm_sba_axil_bridge #(.BusWidth(64)) dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .dmactive_i(dmactive_b), .req_i(req_b), .add_i(add_b),
        .we_i(we_b), .wdata_i(wdata_b), .be_i(be_b), .gnt_o(gnt_b), .r_valid_o(r_valid_b),
        .r_rdata_o(r_rdata_b), .r_err_o(r_err_b), .awaddr_o(awaddr_b), .awprot_o(awprot_b),
        .awvalid_o(awvalid_b), .awready_i(awready_b), .wdata_o(axi_wdata_b), .wstrb_o(wstrb_b),
        .wvalid_o(wvalid_b), .wready_i(wready_b), .bresp_i(bresp_b), .bvalid_i(bvalid_b),
        .bready_o(bready_b), .araddr_o(araddr_b), .arprot_o(arprot_b), .arvalid_o(arvalid_b),
        .arready_i(arready_b), .rdata_i(rdata_b), .rresp_i(rresp_b), .rvalid_i(rvalid_b),
        .rready_o(rready_b), .state_o(state_b)
    );

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_RRESP = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;

    int tests_run = 0;
    int fails = 0;
    logic [32:0] exp_q[$];
    logic [64:0] exp64_q[$];
    logic [32:0] mon_exp;
    logic [64:0] mon_exp64;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] valids_a();
        return {awvalid, wvalid, arvalid, bready, rready};
    endfunction

    // Completion monitors: each r_valid pulse pops one expected {err, rdata}.
    always @(negedge clk) begin
        if (rst_ni && r_valid) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                fails++;
                $display("FAIL resp_a_unexpected: got r_valid err=%0b rdata=0x%0h, expected none", r_err, r_rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                check("resp_a_err", 64'(r_err), 64'(mon_exp[32]));
                check("resp_a_rdata", 64'(r_rdata), 64'(mon_exp[31:0]));
            end
        end
        if (rst_ni && r_valid_b) begin
            if (exp64_q.size() == 0) begin
                tests_run++;
                fails++;
                $display("FAIL resp_b_unexpected: got r_valid err=%0b rdata=0x%0h, expected none", r_err_b, r_rdata_b);
            end else begin
                mon_exp64 = exp64_q.pop_front();
                check("resp_b_err", 64'(r_err_b), 64'(mon_exp64[64]));
                check("resp_b_rdata", r_rdata_b, mon_exp64[63:0]);
            end
        end
    end

    initial begin
        {req, we, add, wdata, be, awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata} = '0;
        {req_b, we_b, add_b, wdata_b, be_b, awready_b, wready_b, bvalid_b, bresp_b} = '0;
        {arready_b, rvalid_b, rresp_b, rdata_b} = '0;
        dmactive = 1'b1;
        dmactive_b = 1'b1;
        rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 64'(state), 64'(S_IDLE));
        check("rst_valids", 64'(valids_a()), 64'(0));
        check("rst_rvalid_err", 64'({r_valid, r_err}), 64'(0));
        check("rst_rdata", 64'(r_rdata), 64'(0));
        check("rst_regs", 64'({awaddr, axi_wdata, wstrb}), 64'(0));
        check("rst_b_valids", 64'({awvalid_b, wvalid_b, arvalid_b, r_valid_b}), 64'(0));
        #2 rst_ni = 1'b1;
        tick();

        // Read, arready and rvalid each one cycle late, OKAY response.
        req = 1'b1; we = 1'b0; add = 32'h1000_0004;
        #1 check("rd_gnt", 64'(gnt), 64'(1));
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        tick(); req = 1'b0;
        check("rd_arvalid", 64'(arvalid), 64'(1));
        check("rd_araddr", 64'(araddr), 64'(32'h1000_0004));
        check("rd_prot", 64'({awprot, arprot}), 64'(0));
        tick(); arready = 1'b1;
        check("rd_arvalid_held", 64'(arvalid), 64'(1));
        tick(); arready = 1'b0;
        check("rd_state_rresp", 64'(state), 64'(S_RRESP));
        check("rd_arvalid_drop", 64'(arvalid), 64'(0));
        check("rd_rready", 64'(rready), 64'(1));
        tick(); rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
        tick(); rvalid = 1'b0;

        // Write granted in the completion cycle; W handshakes 3 cycles before AW.
        check("rd_done_rvalid", 64'(r_valid), 64'(1));
        req = 1'b1; we = 1'b1; add = 32'h2000_0008; wdata = 32'h0000_55AA; be = 4'b0011;
        #1 check("wr_gnt_back_to_back", 64'(gnt), 64'(1));
        exp_q.push_back({1'b0, 32'h0});
        tick(); req = 1'b0; wready = 1'b1;
        check("wr_aw_w_valid", 64'({awvalid, wvalid}), 64'(2'b11));
        check("wr_awaddr", 64'(awaddr), 64'(32'h2000_0008));
        check("wr_wdata", 64'(axi_wdata), 64'(32'h0000_55AA));
        check("wr_wstrb_1", 64'(wstrb), 64'(4'b0011));
        tick(); wready = 1'b0; dmactive = 1'b0;
        check("wr_w_first", 64'({awvalid, wvalid}), 64'(2'b10));
        check("wr_wstrb_2", 64'(wstrb), 64'(4'b0011));
        tick();
        check("wr_aw_held_1", 64'({awvalid, wvalid}), 64'(2'b10));
        tick(); awready = 1'b1;
        check("wr_aw_held_2", 64'({awvalid, wvalid}), 64'(2'b10));
        check("wr_wstrb_3", 64'(wstrb), 64'(4'b0011));
        tick(); awready = 1'b0;
        check("wr_aw_drop", 64'({awvalid, wvalid}), 64'(0));
        check("wr_state_wresp", 64'(state), 64'(S_WRESP));
        check("wr_bready", 64'(bready), 64'(1));
        check("wr_wstrb_4", 64'(wstrb), 64'(4'b0011));
        bvalid = 1'b1; bresp = 2'b00;
        tick(); bvalid = 1'b0; dmactive = 1'b1;
        check("wr_done_rvalid", 64'(r_valid), 64'(1));

        // Read with SLVERR.
        tick();
        req = 1'b1; we = 1'b0; add = 32'h3000_0000;
        #1 check("slverr_gnt", 64'(gnt), 64'(1));
        exp_q.push_back({1'b1, 32'hCAFE_F00D});
        tick(); req = 1'b0; arready = 1'b1;
        tick(); arready = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = 2'b10;
        tick(); rvalid = 1'b0; rresp = 2'b00;

        // Watchdog: arready withheld, error pulse 8 cycles after grant, then drain.
        tick();
        req = 1'b1; we = 1'b0; add = 32'h0BAD_0000;
        #1 check("to_gnt", 64'(gnt), 64'(1));
        exp_q.push_back({1'b1, 32'h0});
        tick(); req = 1'b0;
        repeat (6) tick();
        check("to_not_yet", 64'(r_valid), 64'(0));
        tick();
        check("to_fire", 64'({r_valid, r_err}), 64'(2'b11));
        check("to_state_drain", 64'(state), 64'(S_DRAIN));
        check("to_arvalid_kept", 64'(arvalid), 64'(1));
        tick(); req = 1'b1; we = 1'b0; add = 32'h4000_0000;
        #1 check("to_drain_no_gnt", 64'(gnt), 64'(0));
        tick(); arready = 1'b1;
        check("to_drain_no_gnt_2", 64'(gnt), 64'(0));
        tick(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h1111_1111;
        check("to_drain_rready", 64'(rready), 64'(1));
        check("to_drain_no_gnt_3", 64'(gnt), 64'(0));
        tick(); rvalid = 1'b0;
        check("to_idle_gnt", 64'(gnt), 64'(1));
        exp_q.push_back({1'b0, 32'h1234_5678});
        tick(); req = 1'b0; arready = 1'b1;
        check("to_next_araddr", 64'(araddr), 64'(32'h4000_0000));
        tick(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678;
        tick(); rvalid = 1'b0;

        // dmactive low blocks grants and AXI activity.
        tick();
        dmactive = 1'b0; req = 1'b1; we = 1'b1; add = 32'h5000_0000; wdata = 32'h7777_7777; be = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1 check("dm_off_gnt", 64'(gnt), 64'(0));
            check("dm_off_valids", 64'(valids_a()), 64'(0));
            tick();
        end
        dmactive = 1'b1;
        #1 check("dm_on_gnt", 64'(gnt), 64'(1));
        tick(); req = 1'b0;
        check("rst_mid_aw", 64'({awvalid, wvalid}), 64'(2'b11));
        #2 rst_ni = 1'b0;
        #1 check("rst_mid_valids", 64'(valids_a()), 64'(0));
        check("rst_mid_state", 64'(state), 64'(S_IDLE));
        tick(); tick();
        rst_ni = 1'b1;
        tick();

        // 64-bit instance: write with upper-byte strobes (DECERR), then a read.
        req_b = 1'b1; we_b = 1'b1; add_b = 64'h0000_0001_0000_0010;
        wdata_b = 64'hA5A5_5A5A_0123_4567; be_b = 8'hF0;
        #1 check("b_wr_gnt", 64'(gnt_b), 64'(1));
        exp64_q.push_back({1'b1, 64'h0});
        tick(); req_b = 1'b0; awready_b = 1'b1; wready_b = 1'b1;
        check("b_wdata", axi_wdata_b, 64'hA5A5_5A5A_0123_4567);
        check("b_wstrb", 64'(wstrb_b), 64'(8'hF0));
        check("b_awaddr", awaddr_b, 64'h0000_0001_0000_0010);
        tick(); awready_b = 1'b0; wready_b = 1'b0;
        check("b_state_wresp", 64'(state_b), 64'(S_WRESP));
        bvalid_b = 1'b1; bresp_b = 2'b11;
        tick(); bvalid_b = 1'b0; bresp_b = 2'b00;
        req_b = 1'b1; we_b = 1'b0; add_b = 64'h8000_0000_0000_0000;
        #1 check("b_rd_gnt", 64'(gnt_b), 64'(1));
        exp64_q.push_back({1'b0, 64'hFEDC_BA98_7654_3210});
        tick(); req_b = 1'b0; arready_b = 1'b1;
        check("b_araddr", araddr_b, 64'h8000_0000_0000_0000);
        tick(); arready_b = 1'b0; rvalid_b = 1'b1; rdata_b = 64'hFEDC_BA98_7654_3210;
        tick(); rvalid_b = 1'b0;

        for (int i = 0; i < 20 && (exp_q.size() != 0 || exp64_q.size() != 0); i++) tick();
        tick();
        check("queues_drained", 64'(exp_q.size() + exp64_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
